sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 16-bit asynchronous SRAM between two requesters.
  - Port 0 is the CPU memory interface.
  - Port 1 is the debug/program-loader port.
- Sequences active-low CE/OE/WE/UB/LB strobes with programmable wait states, arbitrates round-robin, and returns read data with a one-cycle ack.
- Sits between the CPU/Mem2IO layer and the SRAM pins at the top level.

Parameters:
WAIT_CYCLES, 2, cycles OE (read) or WE (write) held low; legal range 1..15
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 access request, held until ack0
we0  input  1  port 0 direction, 1 = write
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
be0  input  2  port 0 byte enables, bit1 = upper, bit0 = lower
ack0  output  1  one-cycle completion pulse for port 0
rdata0  output  DATA_W  port 0 read data
req1, we1, addr1, wdata1, be1, ack1, rdata1  same as port 0, for port 1
CE  output  1  SRAM chip enable, active-low
OE  output  1  SRAM output enable, active-low
WE  output  1  SRAM write enable, active-low
UB  output  1  SRAM upper-byte enable, active-low
LB  output  1  SRAM lower-byte enable, active-low
A  output  ADDR_W  SRAM address
Data_out  output  DATA_W  write data to the SRAM pad
Data_oe  output  1  1 = drive Data_out onto the pad
Data_in  input  DATA_W  read data from the SRAM pad
busy  output  1  1 when the FSM is not in IDLE
grant  output  1  index of the port owning the current or last access

Behaviour:
- Reset low, asynchronous:
  - state = IDLE.
  - CE, OE, WE, UB, LB = 1.
  - Data_oe, ack0, ack1, busy = 0.
  - A, Data_out, rdata0, rdata1 = 0.
  - grant = 1, so port 0 wins the first contention.
  - Reset mid-access aborts it with no ack.
- States: IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD. A wait counter is 4 bits.
- IDLE:
  - If any req is high, choose the port: a single requester wins; if both request, the port != grant wins.
  - Latch addr/we/wdata/be of the winner, update grant, load counter = WAIT_CYCLES-1.
  - Go to RD or WR_SETUP.
  - Strobes stay inactive in the IDLE cycle.
- RD:
  - CE = 0, OE = 0, UB = ~be[1], LB = ~be[0].
  - A = latched address; counter decrements each cycle.
  - On the cycle the counter reaches 0, capture Data_in into the granted rdata and go to RD_DONE.
- RD_DONE:
  - All strobes = 1; ack[grant] = 1 for exactly this cycle; go to IDLE.
  - Read latency: ack is asserted WAIT_CYCLES+1 cycles after the IDLE grant cycle.
- WR_SETUP (1 cycle):
  - CE = 0, WE = 1, Data_oe = 1, A and Data_out valid; UB/LB driven per be.
- WR_PULSE (WAIT_CYCLES cycles):
  - WE = 0; CE, A, data and byte enables stable.
- WR_HOLD (1 cycle):
  - WE = 1, CE = 0, Data_oe = 1, data held.
  - ack[grant] = 1; go to IDLE.
  - Write ack is asserted WAIT_CYCLES+2 cycles after the grant cycle.
- OE is never low while Data_oe = 1. WE is never low outside WR_PULSE.
- Bus turnaround: at least one IDLE cycle separates any two accesses.
- Requester rules:
  - After ack, a req still high is treated as a new request in the next IDLE.
  - Inputs change only after ack; the arbiter uses latched copies regardless.
- rdata holds its value until the next read completes on that port. Writes never alter rdata.
- be = 00: the access runs its full timing with UB = LB = 1 and still acks. A read returns whatever Data_in holds.
- busy = (state != IDLE). grant holds its value while idle.

Test Plan:
1. Reset, then port 0 reads 0x00010 with be = 11 and Data_in = 0xBEEF, WAIT_CYCLES = 2 -> OE low for exactly 2 cycles, ack0 three cycles after grant, rdata0 = 0xBEEF, ack1 never asserted.
2. Port 1 writes 0x1234 to 0xFFFFF with be = 10 -> setup/pulse/hold = 1/2/1 cycles, UB = 0, LB = 1, Data_oe high across all 4 cycles, ack1 in the hold cycle.
3. req0 and req1 rise in the same cycle after reset, both kept high -> grant order 0, 1, 0, 1; each access separated by one IDLE cycle.
4. Reset pulled low during WR_PULSE -> WE, CE, OE, UB, LB = 1 and Data_oe = 0 immediately with no clock edge; no ack; after release, the FSM is in IDLE with grant = 1.
5. Write 0xA5A5 to 0x00100 then read 0x00100 on the same port with an SRAM model -> rdata = 0xA5A5; assert OE and WE are never both low in any cycle.
6. WAIT_CYCLES = 1 and WAIT_CYCLES = 15 builds -> read ack latency 2 and 16 cycles, write ack latency 3 and 17 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter and strobe sequencer for a 16-bit async SRAM
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [1:0]        be0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        be1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  input  logic [DATA_W-1:0] Data_in,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        pick;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]  sel_be;

  // On contention the port that did not own the last access wins.
  always_comb begin
    pick      = (req0 && req1) ? ~grant : req1;
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_be    = pick ? be1    : be0;
  end

  // Pin registers double as the latched copy of the granted request.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      CE       <= 1'b1;
      OE       <= 1'b1;
      WE       <= 1'b1;
      UB       <= 1'b1;
      LB       <= 1'b1;
      A        <= '0;
      Data_out <= '0;
      Data_oe  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      grant    <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant <= pick;
            cnt   <= CNT_LOAD;
            A     <= sel_addr;
            UB    <= ~sel_be[1];
            LB    <= ~sel_be[0];
            CE    <= 1'b0;
            busy  <= 1'b1;
            if (sel_we) begin
              Data_out <= sel_wdata;
              Data_oe  <= 1'b1;
              state    <= WR_SETUP;
            end else begin
              OE    <= 1'b0;
              state <= RD;
            end
          end
        end
        RD: begin
          if (cnt == 4'd0) begin
            if (grant) rdata1 <= Data_in;
            else       rdata0 <= Data_in;
            ack0  <= ~grant;
            ack1  <= grant;
            CE    <= 1'b1;
            OE    <= 1'b1;
            UB    <= 1'b1;
            LB    <= 1'b1;
            state <= RD_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        WR_SETUP: begin
          WE    <= 1'b0;
          state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == 4'd0) begin
            WE    <= 1'b1;
            ack0  <= ~grant;
            ack1  <= grant;
            state <= WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          CE      <= 1'b1;
          UB      <= 1'b1;
          LB      <= 1'b1;
          Data_oe <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized self-checking bench for sram_arbiter with a pin-level SRAM model
module tb_sram_arbiter;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0 [NI], req1 [NI], we0 [NI], we1 [NI];
  logic [19:0] addr0 [NI], addr1 [NI];
  logic [15:0] wdata0 [NI], wdata1 [NI];
  logic [1:0]  be0 [NI], be1 [NI];
  logic        ack0 [NI], ack1 [NI];
  logic [15:0] rdata0 [NI], rdata1 [NI];
  logic        ce [NI], oe [NI], wen [NI], ub [NI], lb [NI], doe [NI], busy [NI], grant [NI];
  logic [19:0] a [NI];
  logic [15:0] dout [NI], din [NI];
  logic        use_mem [NI];
  logic [15:0] fixed_din;

  int n_checks = 0;
  int n_fail   = 0;
  int mon_cycles = 0, viol_oe_we = 0, viol_oe_doe = 0, viol_ack = 0, viol_we = 0;

  always #5 clk = ~clk;

  // Instance 0 uses 2 wait states, instance 1 uses 1, instance 2 uses 15.
  generate
    for (genvar g = 0; g < NI; g++) begin : gen_dut
      localparam int WC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic [15:0] mem [1024] = '{default: 16'h0000};

      sram_arbiter #(.WAIT_CYCLES(WC), .ADDR_W(20), .DATA_W(16)) dut (
        .Clk(clk), .Reset(rst_n),
        .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]), .be0(be0[g]),
        .ack0(ack0[g]), .rdata0(rdata0[g]),
        .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]), .be1(be1[g]),
        .ack1(ack1[g]), .rdata1(rdata1[g]),
        .CE(ce[g]), .OE(oe[g]), .WE(wen[g]), .UB(ub[g]), .LB(lb[g]), .A(a[g]),
        .Data_out(dout[g]), .Data_oe(doe[g]), .Data_in(din[g]),
        .busy(busy[g]), .grant(grant[g])
      );

      assign din[g] = use_mem[g] ? mem[a[g][9:0]] : fixed_din;

      always @(negedge clk) begin
        if (!ce[g] && !wen[g]) begin
          if (!ub[g]) mem[a[g][9:0]][15:8] <= dout[g][15:8];
          if (!lb[g]) mem[a[g][9:0]][7:0]  <= dout[g][7:0];
        end
      end
    end
  endgenerate

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int g = 0; g < NI; g++) begin
        mon_cycles++;
        if (!oe[g] && !wen[g]) viol_oe_we++;
        if (!oe[g] && doe[g]) viol_oe_doe++;
        if (ack0[g] && ack1[g]) viol_ack++;
        if (!wen[g] && !(doe[g] && !ce[g])) viol_we++;
      end
    end
  end

  function automatic int wc_of(input int idx);
    return (idx == 0) ? 2 : ((idx == 1) ? 1 : 15);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      req0[g] = 1'b0; req1[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic access(input int idx, input int port, input logic wr, input logic [19:0] ad,
                        input logic [15:0] wd, input logic [1:0] b,
                        output int lat, output int oe_lo, output int we_lo, output int doe_hi,
                        output int we_first, output int other_ack, output int pin_bad, output bit ok);
    lat = 0; oe_lo = 0; we_lo = 0; doe_hi = 0; we_first = -1; other_ack = 0; pin_bad = 0; ok = 0;
    @(negedge clk);
    if (port == 0) begin
      req0[idx] = 1'b1; we0[idx] = wr; addr0[idx] = ad; wdata0[idx] = wd; be0[idx] = b;
    end else begin
      req1[idx] = 1'b1; we1[idx] = wr; addr1[idx] = ad; wdata1[idx] = wd; be1[idx] = b;
    end
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (!oe[idx]) oe_lo++;
      if (!wen[idx]) begin
        we_lo++;
        if (we_first < 0) we_first = lat;
      end
      if (doe[idx]) doe_hi++;
      if (!ce[idx] && (ub[idx] !== ~b[1] || lb[idx] !== ~b[0] || a[idx] !== ad)) pin_bad++;
      if (doe[idx] && dout[idx] !== wd) pin_bad++;
      if ((port == 0) ? ack1[idx] : ack0[idx]) other_ack++;
      if ((port == 0) ? ack0[idx] : ack1[idx]) begin
        ok = 1;
        break;
      end
    end
    if (port == 0) req0[idx] = 1'b0;
    else           req1[idx] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ce[0], oe[0], wen[0], ub[0], lb[0]} !== 5'b11111) begin n_fail++; $display("FAIL rst_strobes: got %b expected 11111", {ce[0], oe[0], wen[0], ub[0], lb[0]}); end
    n_checks++; if ({doe[0], ack0[0], ack1[0], busy[0]} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {doe[0], ack0[0], ack1[0], busy[0]}); end
    n_checks++; if (a[0] !== 20'h0 || dout[0] !== 16'h0) begin n_fail++; $display("FAIL rst_bus: got A=%0h D=%0h expected 0 0", a[0], dout[0]); end
    n_checks++; if (rdata0[0] !== 16'h0 || rdata1[0] !== 16'h0) begin n_fail++; $display("FAIL rst_rdata: got %0h %0h expected 0 0", rdata0[0], rdata1[0]); end
    n_checks++; if (grant[0] !== 1'b1) begin n_fail++; $display("FAIL rst_grant: got %b expected 1", grant[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_basic();
    int lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad;
    bit ok;
    use_mem[0] = 1'b0;
    fixed_din = 16'hBEEF;
    access(0, 0, 1'b0, 20'h00010, 16'h0, 2'b11, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_ack_timeout: got no ack0 expected ack0"); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_checks++; if (oe_lo !== 2) begin n_fail++; $display("FAIL rd_oe_cycles: got %0d expected 2", oe_lo); end
    n_checks++; if (we_lo !== 0 || doe_hi !== 0) begin n_fail++; $display("FAIL rd_no_drive: got we_lo=%0d doe=%0d expected 0 0", we_lo, doe_hi); end
    n_checks++; if (other_ack !== 0) begin n_fail++; $display("FAIL rd_ack1: got %0d expected 0", other_ack); end
    n_checks++; if (pin_bad !== 0) begin n_fail++; $display("FAIL rd_pins: got %0d bad cycles expected 0", pin_bad); end
    n_checks++; if (rdata0[0] !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %0h expected beef", rdata0[0]); end
    n_checks++; if (grant[0] !== 1'b0) begin n_fail++; $display("FAIL rd_grant: got %b expected 0", grant[0]); end
  endtask

  task automatic test_write_basic();
    int lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad;
    bit ok;
    access(0, 1, 1'b1, 20'hFFFFF, 16'h1234, 2'b10, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_ack_timeout: got no ack1 expected ack1"); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    n_checks++; if (we_lo !== 2 || we_first !== 2) begin n_fail++; $display("FAIL wr_pulse: got len=%0d start=%0d expected 2 2", we_lo, we_first); end
    n_checks++; if (doe_hi !== 4) begin n_fail++; $display("FAIL wr_doe_cycles: got %0d expected 4", doe_hi); end
    n_checks++; if (oe_lo !== 0 || other_ack !== 0) begin n_fail++; $display("FAIL wr_oe_ack0: got oe=%0d ack0=%0d expected 0 0", oe_lo, other_ack); end
    n_checks++; if (pin_bad !== 0) begin n_fail++; $display("FAIL wr_pins: got %0d bad cycles expected 0", pin_bad); end
    n_checks++; if (rdata1[0] !== 16'h0 || rdata0[0] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rdata_kept: got %0h %0h expected beef 0", rdata0[0], rdata1[0]); end
    n_checks++; if (gen_dut[0].mem[1023] !== 16'h1200) begin n_fail++; $display("FAIL wr_sram_word: got %0h expected 1200", gen_dut[0].mem[1023]); end
  endtask

  task automatic test_contention();
    int acks, gap, cyc;
    int order [4];
    int gaps [4];
    logic last;
    do_reset();
    use_mem[0] = 1'b0;
    fixed_din = 16'h5A5A;
    acks = 0; gap = 0; cyc = 0;
    @(negedge clk);
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 20'h00020; be0[0] = 2'b11;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 20'h00030; be1[0] = 2'b11;
    while (acks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!busy[0]) gap++;
      if (ack0[0] || ack1[0]) begin
        order[acks] = ack1[0] ? 1 : 0;
        gaps[acks] = gap;
        gap = 0;
        acks++;
      end
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL cont_ack_count: got %0d expected 4", acks); end
    last = 1'b1;
    for (int k = 0; k < acks; k++) begin
      last = ~last;
      n_checks++; if (order[k] !== int'(last)) begin n_fail++; $display("FAIL cont_order[%0d]: got %0d expected %0d", k, order[k], last); end
      if (k > 0) begin
        n_checks++; if (gaps[k] !== 1) begin n_fail++; $display("FAIL cont_idle_gap[%0d]: got %0d expected 1", k, gaps[k]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int cyc, stray;
    cyc = 0; stray = 0;
    @(negedge clk);
    req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 20'h00300; wdata0[0] = 16'h7777; be0[0] = 2'b11;
    while (wen[0] !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (wen[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reach_pulse: got WE=%b expected 0", wen[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({ce[0], oe[0], wen[0], ub[0], lb[0], doe[0]} !== 6'b111110) begin n_fail++; $display("FAIL mid_async_pins: got %b expected 111110", {ce[0], oe[0], wen[0], ub[0], lb[0], doe[0]}); end
    req0[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack0[0] || ack1[0]) stray++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ack0[0] || ack1[0]) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d acks expected 0", stray); end
    n_checks++; if (busy[0] !== 1'b0 || grant[0] !== 1'b1) begin n_fail++; $display("FAIL mid_idle_grant: got busy=%b grant=%b expected 0 1", busy[0], grant[0]); end
  endtask

  task automatic test_write_readback();
    int lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad;
    bit ok;
    use_mem[0] = 1'b1;
    access(0, 0, 1'b1, 20'h00100, 16'hA5A5, 2'b11, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
    n_checks++; if (!ok || lat !== 4) begin n_fail++; $display("FAIL wb_write_lat: got %0d ok=%0d expected 4", lat, ok); end
    access(0, 0, 1'b0, 20'h00100, 16'h0, 2'b11, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
    n_checks++; if (!ok || lat !== 3) begin n_fail++; $display("FAIL wb_read_lat: got %0d ok=%0d expected 3", lat, ok); end
    n_checks++; if (rdata0[0] !== 16'hA5A5) begin n_fail++; $display("FAIL wb_data: got %0h expected a5a5", rdata0[0]); end
  endtask

  task automatic test_random();
    logic [15:0] mm [8];
    logic [15:0] rexp [2];
    bit rvalid [2];
    int lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, port, off;
    bit ok;
    logic wr;
    logic [15:0] wd;
    logic [1:0] b;
    for (int i = 0; i < 8; i++) mm[i] = 16'h0;
    rvalid[0] = 0; rvalid[1] = 0;
    use_mem[0] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      port = int'($urandom % 2);
      wr = 1'($urandom % 2);
      off = int'($urandom % 8);
      wd = 16'($urandom);
      b = 2'($urandom % 4);
      access(0, port, wr, 20'h00200 + 20'(off), wd, b, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
      n_checks++; if (!ok || lat !== (wr ? 4 : 3)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d ok=%0d expected %0d", t, lat, ok, wr ? 4 : 3); end
      n_checks++; if (pin_bad !== 0 || other_ack !== 0) begin n_fail++; $display("FAIL rnd_pins[%0d]: got bad=%0d stray=%0d expected 0 0", t, pin_bad, other_ack); end
      if (wr) begin
        if (b[1]) mm[off][15:8] = wd[15:8];
        if (b[0]) mm[off][7:0]  = wd[7:0];
      end else begin
        rexp[port] = mm[off];
        rvalid[port] = 1;
      end
      if (rvalid[0]) begin
        n_checks++; if (rdata0[0] !== rexp[0]) begin n_fail++; $display("FAIL rnd_rdata0[%0d]: got %0h expected %0h", t, rdata0[0], rexp[0]); end
      end
      if (rvalid[1]) begin
        n_checks++; if (rdata1[0] !== rexp[1]) begin n_fail++; $display("FAIL rnd_rdata1[%0d]: got %0h expected %0h", t, rdata1[0], rexp[1]); end
      end
    end
  endtask

  task automatic test_wait_builds();
    int lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, w;
    bit ok;
    logic [15:0] wd;
    for (int idx = 1; idx < NI; idx++) begin
      w = wc_of(idx);
      use_mem[idx] = 1'b1;
      wd = 16'($urandom);
      access(idx, 1, 1'b1, 20'h00040, wd, 2'b11, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
      n_checks++; if (!ok || lat !== w + 2) begin n_fail++; $display("FAIL wc%0d_write_lat: got %0d expected %0d", w, lat, w + 2); end
      n_checks++; if (we_lo !== w) begin n_fail++; $display("FAIL wc%0d_we_cycles: got %0d expected %0d", w, we_lo, w); end
      access(idx, 0, 1'b0, 20'h00040, 16'h0, 2'b11, lat, oe_lo, we_lo, doe_hi, we_first, other_ack, pin_bad, ok);
      n_checks++; if (!ok || lat !== w + 1) begin n_fail++; $display("FAIL wc%0d_read_lat: got %0d expected %0d", w, lat, w + 1); end
      n_checks++; if (oe_lo !== w) begin n_fail++; $display("FAIL wc%0d_oe_cycles: got %0d expected %0d", w, oe_lo, w); end
      n_checks++; if (rdata0[idx] !== wd) begin n_fail++; $display("FAIL wc%0d_rdata: got %0h expected %0h", w, rdata0[idx], wd); end
    end
  endtask

  task automatic test_protocol_monitor();
    n_checks++; if (mon_cycles == 0) begin n_fail++; $display("FAIL mon_active: got 0 cycles expected >0"); end
    n_checks++; if (viol_oe_we !== 0) begin n_fail++; $display("FAIL mon_oe_we_low: got %0d expected 0", viol_oe_we); end
    n_checks++; if (viol_oe_doe !== 0) begin n_fail++; $display("FAIL mon_oe_with_drive: got %0d expected 0", viol_oe_doe); end
    n_checks++; if (viol_ack !== 0) begin n_fail++; $display("FAIL mon_dual_ack: got %0d expected 0", viol_ack); end
    n_checks++; if (viol_we !== 0) begin n_fail++; $display("FAIL mon_we_outside_write: got %0d expected 0", viol_we); end
  endtask

  initial begin
    rst_n = 1'b0;
    fixed_din = 16'h0;
    for (int g = 0; g < NI; g++) begin
      req0[g] = 1'b0; req1[g] = 1'b0; we0[g] = 1'b0; we1[g] = 1'b0;
      addr0[g] = '0; addr1[g] = '0; wdata0[g] = '0; wdata1[g] = '0;
      be0[g] = 2'b00; be1[g] = 2'b00; use_mem[g] = 1'b1;
    end
    test_reset();
    test_read_basic();
    test_write_basic();
    test_contention();
    test_reset_mid_write();
    test_write_readback();
    test_random();
    test_wait_builds();
    repeat (2) @(negedge clk);
    test_protocol_monitor();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
